id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS pipeline with load-use hazard detection and EX operand muxing.
//  Captures decoded operands/control from ID each cycle and inserts bubbles on hazard or branch flush.
//  Applies ForwardA/ForwardB (from the forwarding unit) to produce final EX operands.
//  Supplies ID_EX_Rs/Rt/AddrC/RegWrite back to the forwarding unit. Also keeps a stall-cycle counter.
// PARAMETERS
//  DATA_W   32  datapath width
//  CNT_W    16  width of stall performance counter
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset (0 = reset)
//  IF_ID_Rs       in   5       Rs field of instruction in ID
//  IF_ID_Rt       in   5       Rt field of instruction in ID
//  ID_UsesRt      in   1       ID instruction reads Rt as a source
//  ID_PCSrc       in   3       ID PC select; 3'b011 = JR/JALR
//  ID_DataA       in   DATA_W  register-file read A
//  ID_DataB       in   DATA_W  register-file read B
//  ID_Imm         in   DATA_W  extended immediate
//  ID_AddrC       in   5       destination register
//  ID_Ctrl        in   CTRL_W  control bundle (fields in package)
//  EX_Flush       in   1       branch taken in EX: squash ID instruction
//  EX_MEM_MemRead in   1       instruction in MEM is a load
//  EX_MEM_AddrC   in   5       destination of instruction in MEM
//  EX_MEM_ALUOut  in   DATA_W  forward source for select 2'b10
//  WB_WriteData   in   DATA_W  forward source for select 2'b01
//  ForwardA       in   2       operand A select
//  ForwardB       in   2       operand B select
//  Stall          out  1       hold PC and IF/ID this cycle
//  ID_EX_Rs       out  5       registered Rs
//  ID_EX_Rt       out  5       registered Rt
//  ID_EX_AddrC    out  5       registered destination
//  ID_EX_RegWrite out  1       registered RegWrite
//  ID_EX_MemRead  out  1       registered MemRead
//  ID_EX_Ctrl     out  CTRL_W  registered control bundle
//  ID_EX_Imm      out  DATA_W  registered immediate
//  EX_OpA         out  DATA_W  forwarded operand A
//  EX_OpB         out  DATA_W  forwarded operand B (pre-ALUSrc)
//  StallCount     out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  - Reset (async, reset==0): every register incl. StallCount = 0 (bubble); Stall = 0.
//  - LoadUse = ID_EX_MemRead && ID_EX_AddrC!=0 && (ID_EX_AddrC==IF_ID_Rs || (ID_UsesRt && ID_EX_AddrC==IF_ID_Rt)).
//  - JrHaz = ID_PCSrc==3'b011 && ((ID_EX_MemRead && ID_EX_AddrC!=0 && ID_EX_AddrC==IF_ID_Rs)
//            || (EX_MEM_MemRead && EX_MEM_AddrC!=0 && EX_MEM_AddrC==IF_ID_Rs)).
//  - Stall = (LoadUse || JrHaz) && !EX_Flush, combinational, same cycle.
//  - Posedge, EX_Flush or Stall: load bubble (RegWrite, MemRead, MemWrite, Branch, Jump fields = 0;
//    AddrC = 0; data fields don't-care, driven 0). Flush has priority over Stall.
//  - Otherwise: capture all ID_* inputs; latency 1 cycle.
//  - JR after load: 2 stall cycles (load in EX, then in MEM); resolves via WB forward.
//  - EX_OpA/B combinational from registered data: 00 -> ID_EX_DataA/B, 10 -> EX_MEM_ALUOut,
//    01 -> WB_WriteData, 11 -> ID_EX_DataA/B (illegal, treated as none).
//  - StallCount += 1 on each cycle with Stall=1; saturates at all-ones, no wrap.
//  - Reset mid-stall: bubble immediately, Stall drops on reset release if no hazard remains.
// STRUCTURE
//  - Package pipe_pkg: CTRL_W, control-field bit indices (RegWrite, MemRead, MemWrite, MemToReg,
//    ALUSrc, ALUFun[5:0], Branch, Jump), PCSRC_JR = 3'b011, FWD_* select constants, BUBBLE_CTRL.
//  - One sub-module: hazard_detect (combinational LoadUse/JrHaz/Stall); register + muxes in top.
// TESTING
//  - lw $2 then add $3,$2,$4 -> Stall=1 one cycle, bubble in ID/EX, then ForwardA=01 gives load data.
//  - lw $2 then jr $2 -> Stall=1 two cycles, StallCount +2, then JR proceeds.
//  - lw $0 then add $3,$0,$4 -> Stall=0 (r0 exempt).
//  - Stall condition with EX_Flush=1 same cycle -> Stall=0, bubble loaded, StallCount unchanged.
//  - ForwardA=10, EX_MEM_ALUOut=32'hDEAD_BEEF -> EX_OpA=32'hDEAD_BEEF; ForwardB=11 -> EX_OpB=ID_EX_DataB.
//  - Force StallCount to 16'hFFFF, stall once more -> stays 16'hFFFF; assert reset -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// pipe_pkg: shared control-bundle layout, PC-select and forwarding constants for the ID/EX stage
package pipe_pkg;
    localparam int CTRL_W            = 13;
    localparam int CTRL_REG_WRITE    = 0;
    localparam int CTRL_MEM_READ     = 1;
    localparam int CTRL_MEM_WRITE    = 2;
    localparam int CTRL_MEM_TO_REG   = 3;
    localparam int CTRL_ALU_SRC      = 4;
    localparam int CTRL_ALU_FUN_LSB  = 5;
    localparam int CTRL_ALU_FUN_MSB  = 10;
    localparam int CTRL_BRANCH       = 11;
    localparam int CTRL_JUMP         = 12;
    localparam logic [2:0] PCSRC_JR    = 3'b011;
    localparam logic [1:0] FWD_NONE    = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_ILLEGAL = 2'b11;
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, forwarding selects and ID/EX register outputs of the stage
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    import pipe_pkg::*;
    logic [4:0]        IF_ID_Rs;
    logic [4:0]        IF_ID_Rt;
    logic              ID_UsesRt;
    logic [2:0]        ID_PCSrc;
    logic [DATA_W-1:0] ID_DataA;
    logic [DATA_W-1:0] ID_DataB;
    logic [DATA_W-1:0] ID_Imm;
    logic [4:0]        ID_AddrC;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic              EX_Flush;
    logic              EX_MEM_MemRead;
    logic [4:0]        EX_MEM_AddrC;
    logic [DATA_W-1:0] EX_MEM_ALUOut;
    logic [DATA_W-1:0] WB_WriteData;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              Stall;
    logic [4:0]        ID_EX_Rs;
    logic [4:0]        ID_EX_Rt;
    logic [4:0]        ID_EX_AddrC;
    logic              ID_EX_RegWrite;
    logic              ID_EX_MemRead;
    logic [CTRL_W-1:0] ID_EX_Ctrl;
    logic [DATA_W-1:0] ID_EX_Imm;
    logic [DATA_W-1:0] EX_OpA;
    logic [DATA_W-1:0] EX_OpB;
    logic [CNT_W-1:0]  StallCount;
    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_PCSrc, ID_DataA, ID_DataB, ID_Imm, ID_AddrC, ID_Ctrl,
               EX_Flush, EX_MEM_MemRead, EX_MEM_AddrC, EX_MEM_ALUOut, WB_WriteData, ForwardA, ForwardB,
        output Stall, ID_EX_Rs, ID_EX_Rt, ID_EX_AddrC, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Ctrl,
               ID_EX_Imm, EX_OpA, EX_OpB, StallCount
    );
    modport master (
        output IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_PCSrc, ID_DataA, ID_DataB, ID_Imm, ID_AddrC, ID_Ctrl,
               EX_Flush, EX_MEM_MemRead, EX_MEM_AddrC, EX_MEM_ALUOut, WB_WriteData, ForwardA, ForwardB,
        input  Stall, ID_EX_Rs, ID_EX_Rt, ID_EX_AddrC, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Ctrl,
               ID_EX_Imm, EX_OpA, EX_OpB, StallCount
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use and JR-after-load detection, suppressed when EX is flushing
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [2:0] id_pc_src,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_addr_c,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_addr_c,
    input  logic       flush,
    output logic       stall
);
    logic ex_load, mem_load, load_use, jr_haz;
    // r0 is never a real producer, so loads targeting it never cause hazards
    always_comb begin
        ex_load  = ex_mem_read && ex_addr_c != 5'd0;
        mem_load = mem_mem_read && mem_addr_c != 5'd0;
        load_use = ex_load && (ex_addr_c == id_rs || (id_uses_rt && ex_addr_c == id_rt));
        jr_haz   = id_pc_src == PCSRC_JR &&
                   ((ex_load && ex_addr_c == id_rs) || (mem_load && mem_addr_c == id_rs));
        stall    = (load_use || jr_haz) && !flush;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard stall, bubble insertion, operand forwarding, stall counter
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic reset,
    id_ex_stage_if.slave bus
);
    logic [DATA_W-1:0] data_a, data_b;
    logic              stall_raw;

    hazard_detect u_hazard (
        .id_rs        (bus.IF_ID_Rs),
        .id_rt        (bus.IF_ID_Rt),
        .id_uses_rt   (bus.ID_UsesRt),
        .id_pc_src    (bus.ID_PCSrc),
        .ex_mem_read  (bus.ID_EX_MemRead),
        .ex_addr_c    (bus.ID_EX_AddrC),
        .mem_mem_read (bus.EX_MEM_MemRead),
        .mem_addr_c   (bus.EX_MEM_AddrC),
        .flush        (bus.EX_Flush),
        .stall        (stall_raw)
    );

    // Stall is held low while reset is asserted so the front end never freezes in reset
    always_comb begin
        bus.Stall          = stall_raw && reset;
        bus.ID_EX_RegWrite = bus.ID_EX_Ctrl[CTRL_REG_WRITE];
        bus.ID_EX_MemRead  = bus.ID_EX_Ctrl[CTRL_MEM_READ];
        bus.EX_OpA         = bus.ForwardA == FWD_MEM ? bus.EX_MEM_ALUOut :
                             bus.ForwardA == FWD_WB  ? bus.WB_WriteData  : data_a;
        bus.EX_OpB         = bus.ForwardB == FWD_MEM ? bus.EX_MEM_ALUOut :
                             bus.ForwardB == FWD_WB  ? bus.WB_WriteData  : data_b;
    end

    // Pipeline register: flush or stall loads an all-zero bubble, otherwise capture ID
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ID_EX_Rs    <= '0;
            bus.ID_EX_Rt    <= '0;
            bus.ID_EX_AddrC <= '0;
            bus.ID_EX_Ctrl  <= BUBBLE_CTRL;
            bus.ID_EX_Imm   <= '0;
            data_a          <= '0;
            data_b          <= '0;
        end else if (bus.EX_Flush || bus.Stall) begin
            bus.ID_EX_Rs    <= '0;
            bus.ID_EX_Rt    <= '0;
            bus.ID_EX_AddrC <= '0;
            bus.ID_EX_Ctrl  <= BUBBLE_CTRL;
            bus.ID_EX_Imm   <= '0;
            data_a          <= '0;
            data_b          <= '0;
        end else begin
            bus.ID_EX_Rs    <= bus.IF_ID_Rs;
            bus.ID_EX_Rt    <= bus.IF_ID_Rt;
            bus.ID_EX_AddrC <= bus.ID_AddrC;
            bus.ID_EX_Ctrl  <= bus.ID_Ctrl;
            bus.ID_EX_Imm   <= bus.ID_Imm;
            data_a          <= bus.ID_DataA;
            data_b          <= bus.ID_DataB;
        end
    end

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus.StallCount <= '0;
        else if (bus.Stall && bus.StallCount != {CNT_W{1'b1}})
            bus.StallCount <= bus.StallCount + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of stalls, bubbles, forwarding muxes and the stall counter
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [12:0] CTRL_LW  = 13'h041B;
    localparam logic [12:0] CTRL_ADD = 13'h0401;
    localparam logic [12:0] CTRL_JR  = 13'h1000;

    id_ex_stage_if #(.DATA_W(32), .CNT_W(16)) bif ();
    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bif));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic [2:0] pc_src, input logic [4:0] addr_c, input logic [12:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        bif.IF_ID_Rs  = rs;
        bif.IF_ID_Rt  = rt;
        bif.ID_UsesRt = uses_rt;
        bif.ID_PCSrc  = pc_src;
        bif.ID_AddrC  = addr_c;
        bif.ID_Ctrl   = ctrl;
        bif.ID_DataA  = a;
        bif.ID_DataB  = b;
        bif.ID_Imm    = imm;
    endtask

    task automatic test_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bif.EX_Flush = 0; bif.EX_MEM_MemRead = 0; bif.EX_MEM_AddrC = 0;
        bif.EX_MEM_ALUOut = 0; bif.WB_WriteData = 0; bif.ForwardA = 0; bif.ForwardB = 0;
        reset = 1'b0;
        tick(); tick();
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bif.Stall); end
        n_checks++; if (bif.ID_EX_AddrC !== 5'd0) begin n_fail++; $display("FAIL reset_addrc got=%0d exp=0", bif.ID_EX_AddrC); end
        n_checks++; if (bif.ID_EX_Ctrl !== 13'd0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", bif.ID_EX_Ctrl); end
        n_checks++; if (bif.StallCount !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bif.StallCount); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        set_id(1, 2, 0, 0, 2, CTRL_LW, 32'd100, 32'd0, 32'd4);
        tick();
        n_checks++; if (bif.ID_EX_MemRead !== 1'b1) begin n_fail++; $display("FAIL lu_memread got=%b exp=1", bif.ID_EX_MemRead); end
        set_id(2, 4, 1, 0, 3, CTRL_ADD, 32'd11, 32'd22, 32'd0);
        #1;
        n_checks++; if (bif.Stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", bif.Stall); end
        tick();
        n_checks++; if (bif.ID_EX_Ctrl !== 13'd0 || bif.ID_EX_AddrC !== 5'd0) begin n_fail++; $display("FAIL lu_bubble ctrl=%h addrc=%0d exp=0/0", bif.ID_EX_Ctrl, bif.ID_EX_AddrC); end
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_drop got=%b exp=0", bif.Stall); end
        n_checks++; if (bif.StallCount !== 16'd1) begin n_fail++; $display("FAIL lu_count got=%0d exp=1", bif.StallCount); end
        tick();
        n_checks++; if (bif.ID_EX_Rs !== 5'd2 || bif.ID_EX_Rt !== 5'd4 || bif.ID_EX_AddrC !== 5'd3) begin n_fail++; $display("FAIL lu_capture rs=%0d rt=%0d c=%0d exp=2/4/3", bif.ID_EX_Rs, bif.ID_EX_Rt, bif.ID_EX_AddrC); end
        bif.ForwardA = 2'b01; bif.WB_WriteData = 32'h0000_1234;
        #1;
        n_checks++; if (bif.EX_OpA !== 32'h0000_1234) begin n_fail++; $display("FAIL lu_fwd_wb got=%h exp=00001234", bif.EX_OpA); end
        n_checks++; if (bif.EX_OpB !== 32'd22) begin n_fail++; $display("FAIL lu_opb got=%h exp=00000016", bif.EX_OpB); end
        bif.ForwardA = 2'b00;
    endtask

    task automatic test_jr_after_load();
        set_id(1, 5, 0, 0, 5, CTRL_LW, 0, 0, 0);
        tick();
        set_id(5, 0, 0, 3'b011, 0, CTRL_JR, 32'h40, 0, 0);
        #1;
        n_checks++; if (bif.Stall !== 1'b1) begin n_fail++; $display("FAIL jr_stall1 got=%b exp=1", bif.Stall); end
        tick();
        bif.EX_MEM_MemRead = 1; bif.EX_MEM_AddrC = 5;
        #1;
        n_checks++; if (bif.Stall !== 1'b1) begin n_fail++; $display("FAIL jr_stall2 got=%b exp=1", bif.Stall); end
        tick();
        bif.EX_MEM_MemRead = 0; bif.EX_MEM_AddrC = 0;
        #1;
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL jr_release got=%b exp=0", bif.Stall); end
        n_checks++; if (bif.StallCount !== 16'd3) begin n_fail++; $display("FAIL jr_count got=%0d exp=3", bif.StallCount); end
        tick();
        n_checks++; if (bif.ID_EX_Ctrl !== CTRL_JR || bif.ID_EX_Rs !== 5'd5) begin n_fail++; $display("FAIL jr_proceed ctrl=%h rs=%0d exp=1000/5", bif.ID_EX_Ctrl, bif.ID_EX_Rs); end
    endtask

    task automatic test_r0_exempt();
        set_id(1, 0, 0, 0, 0, CTRL_LW, 0, 0, 0);
        tick();
        set_id(0, 4, 1, 0, 3, CTRL_ADD, 0, 0, 0);
        #1;
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL r0_loaduse got=%b exp=0", bif.Stall); end
        set_id(0, 0, 0, 3'b011, 0, CTRL_JR, 0, 0, 0);
        bif.EX_MEM_MemRead = 1; bif.EX_MEM_AddrC = 0;
        #1;
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL r0_jr got=%b exp=0", bif.Stall); end
        bif.EX_MEM_MemRead = 0;
        tick();
    endtask

    task automatic test_flush();
        set_id(1, 2, 0, 0, 2, CTRL_LW, 0, 0, 0);
        tick();
        set_id(2, 4, 1, 0, 3, CTRL_ADD, 32'd7, 32'd8, 32'd9);
        bif.EX_Flush = 1;
        #1;
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%b exp=0", bif.Stall); end
        tick();
        bif.EX_Flush = 0;
        n_checks++; if (bif.ID_EX_Ctrl !== 13'd0 || bif.ID_EX_AddrC !== 5'd0) begin n_fail++; $display("FAIL flush_bubble ctrl=%h addrc=%0d exp=0/0", bif.ID_EX_Ctrl, bif.ID_EX_AddrC); end
        n_checks++; if (bif.StallCount !== 16'd3) begin n_fail++; $display("FAIL flush_count got=%0d exp=3", bif.StallCount); end
    endtask

    task automatic test_forwarding();
        set_id(6, 7, 1, 0, 8, CTRL_ADD, 32'h0000_000A, 32'h0000_000B, 32'h0000_0C0C);
        tick();
        n_checks++; if (bif.ID_EX_Imm !== 32'h0000_0C0C) begin n_fail++; $display("FAIL fwd_imm got=%h exp=00000c0c", bif.ID_EX_Imm); end
        bif.EX_MEM_ALUOut = 32'hDEAD_BEEF; bif.WB_WriteData = 32'h5555_AAAA;
        bif.ForwardA = 2'b10; bif.ForwardB = 2'b11;
        #1;
        n_checks++; if (bif.EX_OpA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fwd_a_mem got=%h exp=deadbeef", bif.EX_OpA); end
        n_checks++; if (bif.EX_OpB !== 32'h0000_000B) begin n_fail++; $display("FAIL fwd_b_illegal got=%h exp=0000000b", bif.EX_OpB); end
        bif.ForwardA = 2'b11; bif.ForwardB = 2'b01;
        #1;
        n_checks++; if (bif.EX_OpA !== 32'h0000_000A) begin n_fail++; $display("FAIL fwd_a_illegal got=%h exp=0000000a", bif.EX_OpA); end
        n_checks++; if (bif.EX_OpB !== 32'h5555_AAAA) begin n_fail++; $display("FAIL fwd_b_wb got=%h exp=5555aaaa", bif.EX_OpB); end
        bif.ForwardA = 2'b00; bif.ForwardB = 2'b10;
        #1;
        n_checks++; if (bif.EX_OpA !== 32'h0000_000A) begin n_fail++; $display("FAIL fwd_a_none got=%h exp=0000000a", bif.EX_OpA); end
        n_checks++; if (bif.EX_OpB !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fwd_b_mem got=%h exp=deadbeef", bif.EX_OpB); end
        bif.ForwardB = 2'b00;
    endtask

    task automatic test_saturate_and_reset();
        set_id(7, 0, 0, 3'b011, 0, CTRL_JR, 0, 0, 0);
        bif.EX_MEM_MemRead = 1; bif.EX_MEM_AddrC = 7;
        repeat (65532) tick();
        n_checks++; if (bif.StallCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got=%h exp=ffff", bif.StallCount); end
        tick();
        n_checks++; if (bif.StallCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", bif.StallCount); end
        n_checks++; if (bif.Stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall got=%b exp=1", bif.Stall); end
        reset = 1'b0;
        #1;
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", bif.Stall); end
        n_checks++; if (bif.StallCount !== 16'd0) begin n_fail++; $display("FAIL rst_count got=%h exp=0", bif.StallCount); end
        n_checks++; if (bif.EX_OpA !== 32'd0 || bif.EX_OpB !== 32'd0 || bif.ID_EX_Imm !== 32'd0) begin n_fail++; $display("FAIL rst_data a=%h b=%h imm=%h exp=0", bif.EX_OpA, bif.EX_OpB, bif.ID_EX_Imm); end
        n_checks++; if (bif.ID_EX_Ctrl !== 13'd0 || bif.ID_EX_Rs !== 5'd0 || bif.ID_EX_Rt !== 5'd0) begin n_fail++; $display("FAIL rst_regs ctrl=%h rs=%0d rt=%0d exp=0", bif.ID_EX_Ctrl, bif.ID_EX_Rs, bif.ID_EX_Rt); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bif.EX_MEM_MemRead = 0; bif.EX_MEM_AddrC = 0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if (bif.Stall !== 1'b0) begin n_fail++; $display("FAIL rst_release got=%b exp=0", bif.Stall); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_jr_after_load();
        test_r0_exempt();
        test_flush();
        test_forwarding();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
